// File: rtl/tl_timed_ctrl_pkg.sv
// Shared state and light codes for the two-road traffic light controller.
package tl_timed_ctrl_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tl_timed_ctrl_dff_en_r.sv
// One-bit D flip-flop with synchronous active-low reset (to 0) and load enable.
module tl_timed_ctrl_dff_en_r (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      q <= 1'b0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/tl_timed_ctrl.sv
// Two-road traffic light controller: Moore FSM with a saturating dwell timer.
//  state | meaning
//  S0    | road A green,  road B red
//  S1    | road A yellow, road B red
//  S2    | road A red,    road B green
//  S3    | road A red,    road B yellow
module tl_timed_ctrl
  import tl_timed_ctrl_pkg::*;
#(
  parameter int MIN_GRN    = 10,
  parameter int YEL_CYCLES = 5,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       Ta,
  input  logic       Tb,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] GRN_LAST  = CNT_W'(MIN_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT = CNT_W'(max_int(MIN_GRN, YEL_CYCLES) - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0: if (!Ta && timer_q >= GRN_LAST)  state_d = S1;
      S1: if (timer_q == YEL_LAST)         state_d = S2;
      S2: if (!Tb && timer_q >= GRN_LAST)  state_d = S3;
      S3: if (timer_q == YEL_LAST)         state_d = S0;
      default: state_d = S0;
    endcase
  end

  // Timer restarts on every transition and parks at its ceiling so it never wraps.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (timer_q != TIMER_SAT)
      timer_d = timer_q + CNT_W'(1);
  end

  for (genvar i = 0; i < 2; i++) begin : g_state_ff
    tl_timed_ctrl_dff_en_r u_ff (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .d       (state_d[i]),
      .q       (state_q[i])
    );
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_timer_ff
    tl_timed_ctrl_dff_en_r u_ff (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .d       (timer_d[i]),
      .q       (timer_q[i])
    );
  end

  always_comb begin
    La = RED;
    Lb = RED;
    unique case (state_q)
      S0: begin La = GREEN;  Lb = RED;    end
      S1: begin La = YELLOW; Lb = RED;    end
      S2: begin La = RED;    Lb = GREEN;  end
      S3: begin La = RED;    Lb = YELLOW; end
      default: begin La = RED; Lb = RED; end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_tl_timed_ctrl.sv
// Self-checking bench for tl_timed_ctrl: directed scenarios plus a random run against a dwell-count model.
module tb_tl_timed_ctrl;

  localparam int MIN_GRN = 10;
  localparam int YEL     = 5;

  logic       clk = 1'b0;
  logic       rst_n, en, ta, tb;
  logic [1:0] la, lb, st;

  int errors = 0;
  int checks = 0;

  // Model: phase index 0..3 and number of enabled edges already spent in it.
  int m_st = 0;
  int m_edges = 0;

  always #5 clk = ~clk;

  tl_timed_ctrl dut (
    .clk     (clk),
    .reset_n (rst_n),
    .en      (en),
    .Ta      (ta),
    .Tb      (tb),
    .La      (la),
    .Lb      (lb),
    .state   (st)
  );

  function automatic logic [1:0] light_a(input int s);
    return (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] light_b(input int s);
    return (s == 2) ? 2'b00 : (s == 3) ? 2'b01 : 2'b10;
  endfunction

  // Advance one clock; the model works in terms of dwell lengths, not a timer register.
  task automatic tick();
    bit leave;
    @(posedge clk);
    if (!rst_n) begin
      m_st = 0;
      m_edges = 0;
    end else if (en) begin
      case (m_st)
        0:       leave = !ta && (m_edges + 1 >= MIN_GRN);
        2:       leave = !tb && (m_edges + 1 >= MIN_GRN);
        default: leave = (m_edges + 1 == YEL);
      endcase
      if (leave) begin
        m_st = (m_st + 1) % 4;
        m_edges = 0;
      end else begin
        m_edges++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; ta = 1'b1; tb = 1'b1;
    do_reset();
    checks++;
    if (st !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", st); end
    checks++;
    if (la !== 2'b00) begin errors++; $display("FAIL reset_La got=%b exp=00", la); end
    checks++;
    if (lb !== 2'b10) begin errors++; $display("FAIL reset_Lb got=%b exp=10", lb); end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (st !== 2'b00) begin
        errors++; $display("FAIL hold_s0 cycle=%0d got=%b exp=00", i, st);
      end
    end
  endtask

  task automatic test_full_cycle();
    int n;
    logic [1:0] targets [4];
    int expect_n [4];
    targets  = '{2'b01, 2'b10, 2'b11, 2'b00};
    expect_n = '{MIN_GRN, YEL, MIN_GRN, YEL};
    en = 1'b1; ta = 1'b0; tb = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin ta = 1'b1; tb = 1'b0; end
      n = 0;
      do begin tick(); n++; end while (st !== targets[k] && n < 40);
      checks++;
      if (n != expect_n[k]) begin
        errors++; $display("FAIL cycle_dwell phase=%0d got=%0d exp=%0d", k, n, expect_n[k]);
      end
      checks++;
      if (la !== light_a(m_st) || lb !== light_b(m_st)) begin
        errors++; $display("FAIL cycle_lights phase=%0d got=%b/%b exp=%b/%b",
                           k, la, lb, light_a(m_st), light_b(m_st));
      end
    end
  endtask

  task automatic test_sensor_drop();
    int n;
    en = 1'b1; ta = 1'b1; tb = 1'b1;
    do_reset();
    n = 0;
    repeat (2) begin tick(); n++; end
    ta = 1'b0;
    do begin tick(); n++; end while (st !== 2'b01 && n < 40);
    checks++;
    if (n != MIN_GRN) begin
      errors++; $display("FAIL late_drop_dwell got=%0d exp=%0d", n, MIN_GRN);
    end
    ta = 1'b1;
    do_reset();
    tick();
    ta = 1'b0;
    tick();
    ta = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (st !== 2'b00) begin
        errors++; $display("FAIL pulse_ignored cycle=%0d got=%b exp=00", i, st);
      end
    end
  endtask

  task automatic test_en_freeze();
    int n;
    en = 1'b1; ta = 1'b0; tb = 1'b1;
    do_reset();
    repeat (MIN_GRN + 2) tick();
    checks++;
    if (st !== 2'b01) begin errors++; $display("FAIL freeze_entry got=%b exp=01", st); end
    en = 1'b0;
    ta = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (st !== 2'b01 || la !== 2'b01 || lb !== 2'b10) begin
        errors++; $display("FAIL freeze_hold cycle=%0d got=%b %b %b exp=01 01 10", i, st, la, lb);
      end
    end
    en = 1'b1;
    // Timer shows 2: the current yellow cycle plus two more, then green on road B.
    n = 0;
    do begin tick(); n++; end while (st !== 2'b10 && n < 20);
    checks++;
    if (n != YEL - 2) begin
      errors++; $display("FAIL freeze_resume got=%0d exp=%0d", n, YEL - 2);
    end
  endtask

  task automatic test_reset_in_s2();
    int n;
    en = 1'b1; ta = 1'b0; tb = 1'b1;
    do_reset();
    repeat (MIN_GRN + YEL) tick();
    checks++;
    if (lb !== 2'b00) begin errors++; $display("FAIL s2_entry Lb got=%b exp=00", lb); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (st !== 2'b00 || la !== 2'b00 || lb !== 2'b10) begin
      errors++; $display("FAIL s2_reset got=%b %b %b exp=00 00 10", st, la, lb);
    end
    n = 0;
    do begin tick(); n++; end while (st !== 2'b01 && n < 40);
    checks++;
    if (n != MIN_GRN) begin
      errors++; $display("FAIL s2_reset_timer got=%0d exp=%0d", n, MIN_GRN);
    end
  endtask

  task automatic test_random();
    logic [1:0] prev_st;
    logic       prev_en;
    int         yel_cnt = 0;
    en = 1'b1; ta = 1'b1; tb = 1'b1;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      ta = 1'($urandom_range(0, 1));
      tb = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      prev_st = st;
      prev_en = en;
      tick();
      checks++;
      if (st !== 2'(m_st) || la !== light_a(m_st) || lb !== light_b(m_st)) begin
        errors++; $display("FAIL rand_model cycle=%0d got=%b %b %b exp=%0d %b %b",
                           i, st, la, lb, m_st, light_a(m_st), light_b(m_st));
      end
      checks++;
      if (la !== 2'b10 && lb !== 2'b10) begin
        errors++; $display("FAIL safety cycle=%0d got La=%b Lb=%b exp one red", i, la, lb);
      end
      if ((prev_st == 2'b01 || prev_st == 2'b11) && prev_en) yel_cnt++;
      if ((prev_st == 2'b01 || prev_st == 2'b11) && st !== prev_st) begin
        checks++;
        if (yel_cnt != YEL) begin
          errors++; $display("FAIL yellow_dwell cycle=%0d got=%0d exp=%0d", i, yel_cnt, YEL);
        end
        yel_cnt = 0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; ta = 1'b1; tb = 1'b1;
    test_reset();
    test_full_cycle();
    test_sensor_drop();
    test_en_freeze();
    test_reset_in_s2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
